rr_mux_arbiter: RTL and testbench

- Round-robin controller that shares one generic 1-bit INS:1 multiplexer between INS requesters.
- Arbitrates the `req` lines and registers the winning index onto the mux select `s`.
- Returns a one-hot grant and forwards the granted requester's data bit as `f`/`valid`.
- Sits in front of the shared 1-bit mux in the combinational-circuits datapath; instantiates that mux internally.

---
 rtl/rr_mux_arbiter.sv | 93 +++++++++
 tb/tb_rr_mux_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin owner of a shared INS:1 1-bit mux; optional forced release via `ARB_TIMEOUT_EN
module rr_mux_n1 #(
  parameter int N = 6
) (
  input  logic [N-1:0]         i_d,
  input  logic [$clog2(N)-1:0] i_sel,
  output logic                 o_f
);
  assign o_f = i_d[i_sel];
endmodule

module rr_mux_arbiter #(
  parameter int INS      = 6,
  parameter int MAX_HOLD = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INS-1:0]         req,
  input  logic [INS-1:0]         w,
  output logic [INS-1:0]         gnt,
  output logic [$clog2(INS)-1:0] s,
  output logic                   f,
  output logic                   valid,
  output logic                   timeout
);
  localparam int SW = $clog2(INS);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t          r_state;
  logic [SW-1:0]   r_s, r_ptr, w_win, w_next;
  logic [INS-1:0]  r_gnt;
  logic            r_valid, w_found, w_mux, w_expire;
  int              w_k;
  // search ptr, ptr+1, ... with wrap at INS rather than at 2**SW
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_k     = 0;
    for (int i = 0; i < INS; i++) begin
      w_k = int'(r_ptr) + i;
      w_k = (w_k >= INS) ? w_k - INS : w_k;
      if (!w_found && req[w_k]) begin
        w_found = 1'b1;
        w_win   = SW'(w_k);
      end
    end
  end
  assign w_next = (r_s == SW'(INS - 1)) ? '0 : r_s + 1'b1;
`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] r_cnt;
  logic          r_to;
  assign w_expire = (r_cnt == HW'(MAX_HOLD - 1));
  assign timeout  = r_to;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_to  <= 1'b0;
    end else begin
      r_cnt <= (r_state == GRANT) ? r_cnt + 1'b1 : '0;
      r_to  <= (r_state == GRANT) && req[r_s] && w_expire;
    end
  end
`else
  assign w_expire = 1'b0;
  assign timeout  = (MAX_HOLD < 1);
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_s     <= '0;
      r_ptr   <= '0;
      r_valid <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_found) begin
        r_s     <= w_win;
        r_gnt   <= INS'(1) << w_win;
        r_valid <= 1'b1;
        r_state <= GRANT;
      end
    end else if (!req[r_s] || w_expire) begin
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_ptr   <= w_next;
      r_state <= IDLE;
    end
  end
  rr_mux_n1 #(.N(INS)) u_mux (.i_d(w), .i_sel(r_s), .o_f(w_mux));
  assign gnt   = r_gnt;
  assign s     = r_s;
  assign valid = r_valid;
  assign f     = w_mux & r_valid;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed checks of arbitration order, latency, reset and hold behaviour
module tb_rr_mux_arbiter;
  logic       clk = 1'b0, reset = 1'b1;
  logic [5:0] req = '0, w = '0, gnt;
  logic [2:0] s;
  logic       f, valid, timeout;
  int         checks = 0, errors = 0;
  always #5 clk = ~clk;
  rr_mux_arbiter #(.INS(6), .MAX_HOLD(8)) dut (
    .clk(clk), .reset(reset), .req(req), .w(w), .gnt(gnt), .s(s),
    .f(f), .valid(valid), .timeout(timeout)
  );
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_reset;
    reset = 1'b1; req = 6'b111111; w = 6'b111111;
    tick(2);
    checks++;
    if ({gnt, valid, s, f, timeout} !== 12'b0) begin
      errors++; $display("FAIL reset_values: got gnt=%b valid=%b s=%0d f=%b to=%b want all 0", gnt, valid, s, f, timeout);
    end
    reset = 1'b0;
    tick;
    checks++;
    if (gnt !== 6'b000001 || s !== 3'd0 || valid !== 1'b1) begin
      errors++; $display("FAIL first_grant: got gnt=%b s=%0d valid=%b want 000001 0 1", gnt, s, valid);
    end
    req = '0;
    tick;
    checks++;
    if (gnt !== 6'b0 || valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: got gnt=%b valid=%b want 0 0", gnt, valid);
    end
  endtask
  task automatic test_single;
    req = 6'b001000; w = 6'b001000;
    tick;
    checks++;
    if ({gnt, s, valid, f} !== {6'b001000, 3'd3, 1'b1, 1'b1}) begin
      errors++; $display("FAIL single_grant: got gnt=%b s=%0d valid=%b f=%b want 001000 3 1 1", gnt, s, valid, f);
    end
    w = 6'b110111;
    #1;
    checks++;
    if (f !== 1'b0) begin
      errors++; $display("FAIL f_passthru: got f=%b want 0", f);
    end
    req = '0;
    tick;
    checks++;
    if ({gnt, valid, f, s} !== {6'b0, 1'b0, 1'b0, 3'd3}) begin
      errors++; $display("FAIL single_release: got gnt=%b valid=%b f=%b s=%0d want 0 0 0 3", gnt, valid, f, s);
    end
    req = 6'b100001;
    tick;
    checks++;
    if (s !== 3'd5 || gnt !== 6'b100000) begin
      errors++; $display("FAIL ptr_after_single: got s=%0d gnt=%b want 5 100000", s, gnt);
    end
    req = '0;
    tick;
  endtask
  task automatic test_round_robin;
    int order[4] = '{0, 2, 5, 0};
    req = 6'b100101; w = 6'b100000;
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++;
      if (gnt !== (6'b000001 << order[k]) || s !== 3'(order[k]) || valid !== 1'b1 || f !== (order[k] == 5)) begin
        errors++; $display("FAIL rr_grant%0d: got gnt=%b s=%0d valid=%b f=%b want idx %0d", k, gnt, s, valid, f, order[k]);
      end
      tick;
      checks++;
      if (s !== 3'(order[k]) || valid !== 1'b1) begin
        errors++; $display("FAIL rr_hold%0d: got s=%0d valid=%b want %0d 1", k, s, valid, order[k]);
      end
      req[order[k]] = 1'b0;
      tick;
      checks++;
      if (gnt !== 6'b0 || valid !== 1'b0) begin
        errors++; $display("FAIL rr_idle%0d: got gnt=%b valid=%b want 0 0", k, gnt, valid);
      end
      req = 6'b100101;
    end
    req = '0;
  endtask
  task automatic test_wrap;
    req = 6'b010000;
    tick;
    checks++;
    if (s !== 3'd4) begin
      errors++; $display("FAIL wrap_grant4: got s=%0d want 4", s);
    end
    req = '0;
    tick;
    req = 6'b000011;
    tick;
    checks++;
    if (gnt !== 6'b000001) begin
      errors++; $display("FAIL wrap_to_0: got gnt=%b want 000001", gnt);
    end
    req = 6'b000010;
    tick;
    req = 6'b000011;
    tick;
    checks++;
    if (gnt !== 6'b000010) begin
      errors++; $display("FAIL wrap_next_1: got gnt=%b want 000010", gnt);
    end
    req = '0;
    tick;
  endtask
  task automatic test_reset_mid;
    req = 6'b010000;
    tick;
    checks++;
    if (gnt !== 6'b010000) begin
      errors++; $display("FAIL mid_pre: got gnt=%b want 010000", gnt);
    end
    reset = 1'b1;
    tick;
    checks++;
    if ({gnt, valid, s} !== 10'b0) begin
      errors++; $display("FAIL mid_reset: got gnt=%b valid=%b s=%0d want 0 0 0", gnt, valid, s);
    end
    reset = 1'b0; req = 6'b010001;
    tick;
    checks++;
    if (gnt !== 6'b000001) begin
      errors++; $display("FAIL mid_after: got gnt=%b want 000001", gnt);
    end
    req = '0;
    tick;
  endtask
  task automatic test_back_to_back;
    req = 6'b000100;
    tick;
    req = 6'b111111;
    tick;
    checks++;
    if (gnt !== 6'b000100) begin
      errors++; $display("FAIL no_preempt: got gnt=%b want 000100", gnt);
    end
    req = 6'b001000;
    tick;
    checks++;
    if (gnt !== 6'b0) begin
      errors++; $display("FAIL release_first: got gnt=%b want 0", gnt);
    end
    tick;
    checks++;
    if (gnt !== 6'b001000) begin
      errors++; $display("FAIL then_grant: got gnt=%b want 001000", gnt);
    end
    req = '0;
    tick;
    req = 6'b001000;
    tick;
    checks++;
    if (gnt !== 6'b001000) begin
      errors++; $display("FAIL same_again: got gnt=%b want 001000", gnt);
    end
    req = '0;
    tick;
  endtask
  task automatic test_hold;
    logic [5:0] e;
    reset = 1'b1; req = '0;
    tick;
    reset = 1'b0; req = 6'b000110;
`ifdef ARB_TIMEOUT_EN
    for (int r = 0; r < 2; r++) begin
      e = (r == 0) ? 6'b000010 : 6'b000100;
      for (int c = 0; c < 8; c++) begin
        tick;
        checks++;
        if (gnt !== e || timeout !== 1'b0) begin
          errors++; $display("FAIL hold%0d_c%0d: got gnt=%b to=%b want %b 0", r, c, gnt, timeout, e);
        end
      end
      tick;
      checks++;
      if (gnt !== 6'b0 || timeout !== 1'b1) begin
        errors++; $display("FAIL timeout%0d: got gnt=%b to=%b want 0 1", r, gnt, timeout);
      end
    end
    tick;
    checks++;
    if (gnt !== 6'b000010 || timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_rearb: got gnt=%b to=%b want 000010 0", gnt, timeout);
    end
`else
    for (int c = 0; c < 12; c++) begin
      e = 6'b000010;
      tick;
      checks++;
      if (gnt !== e || timeout !== 1'b0) begin
        errors++; $display("FAIL hold_c%0d: got gnt=%b to=%b want %b 0", c, gnt, timeout, e);
      end
    end
`endif
    req = '0;
    tick;
  endtask
  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_wrap;
    test_reset_mid;
    test_back_to_back;
    test_hold;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
